// File: rtl/ysyx_25030093_arbiter.sv
// ysyx_25030093_arbiter: shares one SRAM between the IFU (read) and LSU (read/write), one transaction at a time.
// Build option YSYX_25030093_ARB_RR_EN: alternate IFU/LSU on read-read conflicts (default: LSU read always wins).
module ysyx_25030093_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] IFU_SRAM_araddr,
    input  logic        IFU_SRAM_arvalid,
    output logic        SRAM_IFU_arready,
    output logic [31:0] SRAM_IFU_rdata,
    output logic        SRAM_IFU_rvalid,
    input  logic        IFU_SRAM_rready,

    input  logic [31:0] LSU_SRAM_araddr,
    input  logic        LSU_SRAM_arvalid,
    output logic        SRAM_LSU_arready,
    output logic [31:0] SRAM_LSU_rdata,
    output logic        SRAM_LSU_rvalid,
    input  logic        LSU_SRAM_rready,

    input  logic [31:0] LSU_SRAM_awaddr,
    input  logic        LSU_SRAM_awvalid,
    output logic        SRAM_LSU_awready,
    input  logic [31:0] LSU_SRAM_wdata,
    input  logic [7:0]  LSU_SRAM_wstrb,
    input  logic        LSU_SRAM_wvalid,
    output logic        SRAM_LSU_wready,
    output logic        SRAM_LSU_bvalid,
    input  logic        LSU_SRAM_bready,

    output logic [31:0] SRAM_araddr,
    output logic        SRAM_arvalid,
    input  logic        SRAM_arready,
    input  logic [31:0] SRAM_rdata,
    input  logic        SRAM_rvalid,
    output logic        SRAM_rready,
    output logic [31:0] SRAM_awaddr,
    output logic        SRAM_awvalid,
    input  logic        SRAM_awready,
    output logic [31:0] SRAM_wdata,
    output logic [7:0]  SRAM_wstrb,
    output logic        SRAM_wvalid,
    input  logic        SRAM_wready,
    input  logic        SRAM_bvalid,
    output logic        SRAM_bready
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

    state_e state_q;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;
`ifdef YSYX_25030093_ARB_RR_EN
    logic   last_lsu_q;
`endif

    logic lsu_wr_req;
    logic grant_lsu_rd;
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign SRAM_IFU_rdata = SRAM_rdata;
    assign SRAM_LSU_rdata = SRAM_rdata;

    always_comb begin
        SRAM_IFU_arready = 1'b0;
        SRAM_IFU_rvalid  = 1'b0;
        SRAM_LSU_arready = 1'b0;
        SRAM_LSU_rvalid  = 1'b0;
        SRAM_LSU_awready = 1'b0;
        SRAM_LSU_wready  = 1'b0;
        SRAM_LSU_bvalid  = 1'b0;
        SRAM_araddr      = '0;
        SRAM_arvalid     = 1'b0;
        SRAM_rready      = 1'b0;
        SRAM_awaddr      = '0;
        SRAM_awvalid     = 1'b0;
        SRAM_wdata       = '0;
        SRAM_wstrb       = '0;
        SRAM_wvalid      = 1'b0;
        SRAM_bready      = 1'b0;
        unique case (state_q)
            IFU_RD: begin
                SRAM_araddr      = IFU_SRAM_araddr;
                SRAM_arvalid     = IFU_SRAM_arvalid & ~ar_done_q;
                SRAM_IFU_arready = SRAM_arready & ~ar_done_q;
                SRAM_IFU_rvalid  = SRAM_rvalid;
                SRAM_rready      = IFU_SRAM_rready;
            end
            LSU_RD: begin
                SRAM_araddr      = LSU_SRAM_araddr;
                SRAM_arvalid     = LSU_SRAM_arvalid & ~ar_done_q;
                SRAM_LSU_arready = SRAM_arready & ~ar_done_q;
                SRAM_LSU_rvalid  = SRAM_rvalid;
                SRAM_rready      = LSU_SRAM_rready;
            end
            LSU_WR: begin
                // aw and w complete independently; each done flag blocks a re-issue
                SRAM_awaddr      = LSU_SRAM_awaddr;
                SRAM_awvalid     = LSU_SRAM_awvalid & ~aw_done_q;
                SRAM_LSU_awready = SRAM_awready & ~aw_done_q;
                SRAM_wdata       = LSU_SRAM_wdata;
                SRAM_wstrb       = LSU_SRAM_wstrb;
                SRAM_wvalid      = LSU_SRAM_wvalid & ~w_done_q;
                SRAM_LSU_wready  = SRAM_wready & ~w_done_q;
                SRAM_LSU_bvalid  = SRAM_bvalid;
                SRAM_bready      = LSU_SRAM_bready;
            end
            default: ;
        endcase
    end

    assign ar_hs = SRAM_arvalid & SRAM_arready;
    assign r_hs  = SRAM_rvalid & SRAM_rready;
    assign aw_hs = SRAM_awvalid & SRAM_awready;
    assign w_hs  = SRAM_wvalid & SRAM_wready;
    assign b_hs  = SRAM_bvalid & SRAM_bready;

    assign lsu_wr_req = LSU_SRAM_awvalid | LSU_SRAM_wvalid;

`ifdef YSYX_25030093_ARB_RR_EN
    // On a read-read conflict the LSU wins only if the IFU was served last
    assign grant_lsu_rd = LSU_SRAM_arvalid & (~IFU_SRAM_arvalid | ~last_lsu_q);
`else
    assign grant_lsu_rd = LSU_SRAM_arvalid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef YSYX_25030093_ARB_RR_EN
            last_lsu_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    ar_done_q <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (lsu_wr_req) begin
                        state_q <= LSU_WR;
                    end else if (grant_lsu_rd) begin
                        state_q <= LSU_RD;
                    end else if (IFU_SRAM_arvalid) begin
                        state_q <= IFU_RD;
                    end
                end
                IFU_RD, LSU_RD: begin
                    if (ar_hs) begin
                        ar_done_q <= 1'b1;
                    end
                    if (r_hs) begin
                        state_q <= IDLE;
`ifdef YSYX_25030093_ARB_RR_EN
                        last_lsu_q <= (state_q == LSU_RD);
`endif
                    end
                end
                LSU_WR: begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done_q <= 1'b1;
                    end
                    if (b_hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_25030093_arbiter.md
# ysyx_25030093_arbiter

Two-master, one-slave AXI-lite-style arbiter between the CPU's fetch/memory-access units and a single shared SRAM. Masters are the IFU (read-only) and the LSU (read and write); the slave is one `ysyx_25030093_SRAM`. It replaces the two private SRAM instances so that instruction and data accesses share one memory. One transaction is in flight at a time; the grant is held from address acceptance until the response handshake completes.

## Interface
- No parameters. Address/data 32 bits, wstrb 8 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- IFU read port (slave side of arbiter):
  - `IFU_SRAM_araddr` in 32, `IFU_SRAM_arvalid` in 1, `SRAM_IFU_arready` out 1
  - `SRAM_IFU_rdata` out 32, `SRAM_IFU_rvalid` out 1, `IFU_SRAM_rready` in 1
- LSU read port: `LSU_SRAM_araddr` in 32, `LSU_SRAM_arvalid` in 1, `SRAM_LSU_arready` out 1, `SRAM_LSU_rdata` out 32, `SRAM_LSU_rvalid` out 1, `LSU_SRAM_rready` in 1.
- LSU write port:
  - `LSU_SRAM_awaddr` in 32, `LSU_SRAM_awvalid` in 1, `SRAM_LSU_awready` out 1
  - `LSU_SRAM_wdata` in 32, `LSU_SRAM_wstrb` in 8, `LSU_SRAM_wvalid` in 1, `SRAM_LSU_wready` out 1
  - `SRAM_LSU_bvalid` out 1, `LSU_SRAM_bready` in 1
- Slave port: `SRAM_araddr`, `SRAM_arvalid`, `SRAM_rready`, `SRAM_awaddr`, `SRAM_awvalid`, `SRAM_wdata`, `SRAM_wstrb`, `SRAM_wvalid`, `SRAM_bready` are outputs. `SRAM_arready`, `SRAM_rdata` (32), `SRAM_rvalid`, `SRAM_awready`, `SRAM_wready`, `SRAM_bvalid` are inputs.

## Operation
- Registered state: IDLE, IFU_RD, LSU_RD, LSU_WR.
- Per-grant flags: `ar_done`, `aw_done`, `w_done`, all cleared on entering any grant state.
- IDLE: no forwarding. Every master-facing ready/valid output and every slave-facing valid/ready output is 0. Slave address, data and strobe outputs are 0.
- IDLE arbitration, priority high to low:
  - LSU write (`awvalid | wvalid`) -> LSU_WR
  - LSU read -> LSU_RD
  - IFU read -> IFU_RD
  - A read-read conflict is resolved per Configuration.
- IFU_RD / LSU_RD:
  - Granted master's ar and r signals are wired combinationally to the slave.
  - `SRAM_arvalid` = master arvalid & ~`ar_done`; `ar_done` sets on the ar handshake.
  - On the r handshake (`SRAM_rvalid & rready`), go to IDLE.
- LSU_WR:
  - aw and w are forwarded independently, each gated by its own done flag.
  - b is forwarded to the LSU; on the b handshake, go to IDLE.
- Non-granted master always sees arready/awready/wready/rvalid/bvalid = 0.
- `SRAM_IFU_rdata` and `SRAM_LSU_rdata` both carry `SRAM_rdata`; only rvalid is steered.
- Masters must hold valid and payload stable until the handshake; the arbiter does not latch payloads.

## Timing
- Reset, at any time including mid-transaction: state goes to IDLE, flags clear, all outputs 0 immediately (asynchronous). The slave is assumed reset by the same `rst`.
- Arbitration latency: a request seen in IDLE at cycle N is granted from N+1, so the slave first sees arvalid/awvalid at N+1. Minimum one-cycle bubble.
- The response-handshake cycle returns the state to IDLE at the next edge. Back-to-back transactions are therefore separated by at least one IDLE cycle.
- A request that deasserts before being granted is dropped; no grant is issued for it.
- A second ar from the granted master after `ar_done` is not forwarded until the grant ends.
- Slave rvalid/bvalid arriving in the same cycle as ar/aw acceptance is honoured.

## Configuration
- `YSYX_25030093_ARB_RR_EN` defined: on a simultaneous IFU read and LSU read in IDLE, grant the master not served by the last completed read. The last-served bit resets to IFU, so the first conflict goes to LSU. A pending LSU write still has top priority.
- Undefined: fixed priority; LSU read always beats IFU read. The last-served register is not built.

## Test plan
- IFU alone: araddr=0x80000000, slave returns rdata=0x00000413 -> grant at N+1, `SRAM_IFU_rvalid`=1 with that data, LSU sees rvalid=0, state back to IDLE.
- LSU write: awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=0x0F, with aw and w accepted on different cycles -> each forwarded exactly once, bvalid reaches the LSU, then IDLE.
- Conflict, LSU write vs IFU read in the same cycle -> LSU_WR first. IFU is granted only after the b handshake plus one IDLE cycle; IFU arready stays 0 throughout the write.
- Read-read conflict on two consecutive occasions:
  - Without the macro: LSU, LSU.
  - With the macro: LSU, then IFU.
- Reset asserted in LSU_RD after ar accepted, before rvalid -> outputs 0 the same cycle. After release, a fresh IFU read completes normally with no stale rvalid.
- Slave delays rvalid 3 cycles and the master holds rready=0 for 2 more -> grant held, rdata stable, no second ar issued.
